// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter (IF vs LSU).
// Anti-starvation for IF is compiled in when MEM_ARB_ANTI_STARVE_EN is defined.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  localparam int DEF_WIDTH        = 64;
  localparam int DEF_MASK_W       = 8;
  localparam int DEF_STARVE_LIMIT = 4;

  // Counter width able to hold the value 'limit' itself.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant logic for the memory-port arbiter: LSU priority, optional IF anti-starvation.
// Counter present only when MEM_ARB_ANTI_STARVE_EN is defined.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req_valid,
  input  logic if_flush,
  input  logic lsu_req_valid,
  output logic grant_if,
  output logic grant_lsu
);

  // A fetch that is being flushed in the same cycle is not a real request.
  logic if_eligible;
  assign if_eligible = if_req_valid && !if_flush;

`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             force_if;

  always_comb begin
    force_if  = if_eligible && (starve_q == CNT_MAX);
    grant_lsu = arb_en && lsu_req_valid && !force_if;
    grant_if  = arb_en && if_eligible && !grant_lsu;
    starve_d  = starve_q;
    // Only IDLE arbitration cycles move the counter; it saturates at the limit.
    if (arb_en) begin
      if (!if_eligible || grant_if) begin
        starve_d = '0;
      end else if (starve_q != CNT_MAX) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  localparam int unused_limit = STARVE_LIMIT;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    grant_lsu = arb_en && lsu_req_valid;
    grant_if  = arb_en && if_eligible && !lsu_req_valid;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access in flight.
// Build with MEM_ARB_ANTI_STARVE_EN to guarantee IF progress under constant LSU traffic.
//
// Handshake: a request transfers in the cycle where valid && ready are both high;
// valid must not depend on ready, and mem_req_* holds stable until mem_req_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MASK_W       = DEF_MASK_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [WIDTH-1:0]  if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [WIDTH-1:0]  if_resp_rdata,
  input  logic              if_flush,
  input  logic              lsu_req_valid,
  input  logic [WIDTH-1:0]  lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [WIDTH-1:0]  lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [WIDTH-1:0]  lsu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [WIDTH-1:0]  mem_req_addr,
  output logic              mem_req_wen,
  output logic [WIDTH-1:0]  mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [WIDTH-1:0]  mem_resp_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic live;
  logic arb_en;
  logic grant_if;
  logic grant_lsu;
  logic if_stale;

  // Outputs are forced quiet while rst is high, even mid-transaction.
  assign live   = !rst;
  assign arb_en = live && (state_q == ST_IDLE);

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk           (clk),
    .rst           (rst),
    .arb_en        (arb_en),
    .if_req_valid  (if_req_valid),
    .if_flush      (if_flush),
    .lsu_req_valid (lsu_req_valid),
    .grant_if      (grant_if),
    .grant_lsu     (grant_lsu)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    drop_d         = drop_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    mem_req_valid  = 1'b0;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;
    if_stale       = (owner_q == OWN_IF) && if_flush;

    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = ST_REQ;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = live;
        if (if_stale) drop_d = 1'b1;
        if (mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        // A flush landing with the response already makes that response stale.
        if_resp_valid  = live && (owner_q == OWN_IF) && mem_resp_valid && !(drop_q || if_stale);
        lsu_resp_valid = live && (owner_q == OWN_LSU) && mem_resp_valid;
        if (if_stale) drop_d = 1'b1;
        if (mem_resp_valid) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign if_req_ready   = grant_if;
  assign lsu_req_ready  = grant_lsu;
  assign if_resp_rdata  = mem_resp_rdata;
  assign lsu_resp_rdata = mem_resp_rdata;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign busy           = live && (state_q != ST_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a behavioural memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int W     = 64;
  localparam int MW    = 8;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid;
  logic [W-1:0]  if_req_addr;
  logic          if_req_ready;
  logic          if_resp_valid;
  logic [W-1:0]  if_resp_rdata;
  logic          if_flush;
  logic          lsu_req_valid;
  logic [W-1:0]  lsu_req_addr;
  logic          lsu_req_wen;
  logic [W-1:0]  lsu_req_wdata;
  logic [MW-1:0] lsu_req_wmask;
  logic          lsu_req_ready;
  logic          lsu_resp_valid;
  logic [W-1:0]  lsu_resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [W-1:0]  mem_req_addr;
  logic          mem_req_wen;
  logic [W-1:0]  mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_resp_valid;
  logic [W-1:0]  mem_resp_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_model[logic [W-1:0]];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  mem_port_arbiter #(
    .WIDTH(W), .MASK_W(MW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata), .if_flush(if_flush),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    if_flush       = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  // Called in the IDLE cycle where a grant happens; runs a 1-cycle memory to completion.
  task automatic run_mem(input logic [W-1:0] rdata);
    tick();
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  task automatic mem_write(input logic [W-1:0] a, input logic [W-1:0] d, input logic [MW-1:0] m);
    logic [W-1:0] v;
    v = mem_read(a);
    for (int b = 0; b < MW; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = v;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    if_req_valid   = 1'b1;
    lsu_req_valid  = 1'b1;
    mem_resp_valid = 1'b1;
    tick();
    tick();
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready got=%b exp=0", if_req_ready); end
    checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready got=%b exp=0", lsu_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got=%b exp=0", mem_req_valid); end
    checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_if_resp got=%b exp=0", if_resp_valid); end
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_lsu_resp got=%b exp=0", lsu_resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    checks++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !== '0) begin errors++; $display("FAIL rst_payload got=%h exp=0", mem_req_addr); end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL ifrd_ready got=%b exp=1", if_req_ready); end
    checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL ifrd_lsu_ready got=%b exp=0", lsu_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL ifrd_mem_early got=%b exp=0", mem_req_valid); end
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL ifrd_mem_valid got=%b exp=1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL ifrd_addr got=%h exp=80000000", mem_req_addr); end
    checks++; if ({mem_req_wen, mem_req_wmask, mem_req_wdata} !== '0) begin errors++; $display("FAIL ifrd_wr_fields got=%b/%h/%h exp=0", mem_req_wen, mem_req_wmask, mem_req_wdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ifrd_busy_t1 got=%b exp=1", busy); end
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h13;
    #1;
    checks++; if (if_resp_valid !== 1'b1) begin errors++; $display("FAIL ifrd_resp_valid got=%b exp=1", if_resp_valid); end
    checks++; if (if_resp_rdata !== 64'h13) begin errors++; $display("FAIL ifrd_rdata got=%h exp=13", if_resp_rdata); end
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifrd_lsu_resp got=%b exp=0", lsu_resp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ifrd_busy_t2 got=%b exp=1", busy); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ifrd_busy_t3 got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_priority();
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0040;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 64'h8000_1000;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 64'hDEAD_BEEF;
    lsu_req_wmask = 8'h0F;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL prio_lsu_ready got=%b exp=1", lsu_req_ready); end
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL prio_if_ready got=%b exp=0", if_req_ready); end
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if ({mem_req_valid, mem_req_wen} !== 2'b11) begin errors++; $display("FAIL prio_mem_vw got=%b exp=11", {mem_req_valid, mem_req_wen}); end
    checks++; if (mem_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL prio_addr got=%h exp=80001000", mem_req_addr); end
    checks++; if (mem_req_wdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL prio_wdata got=%h exp=deadbeef", mem_req_wdata); end
    checks++; if (mem_req_wmask !== 8'h0F) begin errors++; $display("FAIL prio_wmask got=%h exp=0f", mem_req_wmask); end
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL prio_if_ready_req got=%b exp=0", if_req_ready); end
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0;
    #1;
    checks++; if ({lsu_resp_valid, if_resp_valid} !== 2'b10) begin errors++; $display("FAIL prio_lsu_ack got=%b exp=10", {lsu_resp_valid, if_resp_valid}); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL prio_if_next got=%b exp=1", if_req_ready); end
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if ({mem_req_addr, mem_req_wen} !== {64'h8000_0040, 1'b0}) begin errors++; $display("FAIL prio_if_payload got=%h/%b exp=80000040/0", mem_req_addr, mem_req_wen); end
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h1234;
    #1;
    checks++; if ({if_resp_valid, if_resp_rdata} !== {1'b1, 64'h1234}) begin errors++; $display("FAIL prio_if_resp got=%b/%h exp=1/1234", if_resp_valid, if_resp_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 64'h8000_2000;
    lsu_req_wen   = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL stall_grant got=%b exp=1", lsu_req_ready); end
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0080;
    lsu_req_addr = 64'h8000_3000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 64'h8000_2000}) begin errors++; $display("FAIL stall_hold%0d got=%b/%h exp=1/80002000", c, mem_req_valid, mem_req_addr); end
      checks++; if ({if_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready%0d got=%b exp=00", c, {if_req_ready, lsu_req_ready}); end
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", mem_req_valid); end
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++; if ({if_req_ready, lsu_req_ready, mem_req_valid, lsu_resp_valid} !== 4'b0000) begin errors++; $display("FAIL stall_resp_wait got=%b exp=0000", {if_req_ready, lsu_req_ready, mem_req_valid, lsu_resp_valid}); end
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hCAFE_F00D_0000_0001;
    #1;
    checks++; if ({lsu_resp_valid, lsu_resp_rdata} !== {1'b1, 64'hCAFE_F00D_0000_0001}) begin errors++; $display("FAIL stall_resp got=%b/%h exp=1/cafef00d00000001", lsu_resp_valid, lsu_resp_rdata); end
    tick();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b0;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL stall_if_after got=%b exp=1", if_req_ready); end
    run_mem(64'h0);
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    // flush one cycle before the response
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0100;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL flush_a_grant got=%b exp=1", if_req_ready); end
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if_flush      = 1'b1;
    #1;
    checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_a_pre got=%b exp=0", if_resp_valid); end
    tick();
    if_flush       = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h55;
    #1;
    checks++; if ({if_resp_valid, busy} !== 2'b01) begin errors++; $display("FAIL flush_a_drop got=%b exp=01", {if_resp_valid, busy}); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_a_idle got=%b exp=0", busy); end
    // flush in the same cycle as the response
    if_req_valid = 1'b1;
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    if_flush       = 1'b1;
    #1;
    checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_b_same got=%b exp=0", if_resp_valid); end
    tick();
    clear_inputs();
    // flush while the request is stalled in REQ
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0108;
    tick();
    if_req_valid = 1'b0;
    if_flush     = 1'b1;
    tick();
    if_flush      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_c_req got=%b exp=0", if_resp_valid); end
    tick();
    clear_inputs();
    // request together with flush in IDLE is not granted
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0200;
    if_flush     = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL flush_d_idle got=%b exp=0", if_req_ready); end
    tick();
    if_flush = 1'b0;
    #1;
    checks++; if ({busy, if_req_ready} !== 2'b01) begin errors++; $display("FAIL flush_d_retry got=%b exp=01", {busy, if_req_ready}); end
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0000_0000_0093;
    #1;
    checks++; if ({if_resp_valid, if_resp_rdata} !== {1'b1, 64'h93}) begin errors++; $display("FAIL flush_d_normal got=%b/%h exp=1/93", if_resp_valid, if_resp_rdata); end
    tick();
    clear_inputs();
    // flush has no effect on an LSU access
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 64'h8000_4000;
    if_flush      = 1'b1;
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h77;
    #1;
    checks++; if ({lsu_resp_valid, lsu_resp_rdata} !== {1'b1, 64'h77}) begin errors++; $display("FAIL flush_e_lsu got=%b/%h exp=1/77", lsu_resp_valid, lsu_resp_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starve();
    int cnt;
    int first_if;
    int exp_first;
    bit exp_if;
    cnt       = 0;
    first_if  = 0;
    exp_first = STARVE_EN ? LIMIT + 1 : 0;
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0300;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 64'h8000_5000;
    for (int n = 1; n <= 12; n++) begin
      if (STARVE_EN && cnt == LIMIT) begin
        exp_if = 1'b1;
        cnt    = 0;
      end else begin
        exp_if = 1'b0;
        if (cnt < LIMIT) cnt++;
      end
      #1;
      checks++; if ({if_req_ready, lsu_req_ready} !== {exp_if, !exp_if}) begin errors++; $display("FAIL starve_arb%0d got=%b exp=%b", n, {if_req_ready, lsu_req_ready}, {exp_if, !exp_if}); end
      if (if_req_ready && first_if == 0) first_if = n;
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
    end
    checks++; if (first_if !== exp_first) begin errors++; $display("FAIL starve_first got=%0d exp=%0d", first_if, exp_first); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0400;
    tick();
    if_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_in_req got=%b exp=1", mem_req_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({mem_req_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_during got=%b exp=00", {mem_req_valid, busy}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({busy, mem_req_valid, dbg_state} !== 4'b0000) begin errors++; $display("FAIL rmid_after got=%b exp=0000", {busy, mem_req_valid, dbg_state}); end
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0500;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_fresh_grant got=%b exp=1", if_req_ready); end
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_addr !== 64'h8000_0500) begin errors++; $display("FAIL rmid_fresh_addr got=%h exp=80000500", mem_req_addr); end
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hABCD;
    #1;
    checks++; if ({if_resp_valid, if_resp_rdata} !== {1'b1, 64'hABCD}) begin errors++; $display("FAIL rmid_fresh_resp got=%b/%h exp=1/abcd", if_resp_valid, if_resp_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int cnt;
    int w;  // 0 = IF, 1 = LSU, 2 = no grant
    bit lv, iv, fl, f, dropped;
    logic [W-1:0]  e_addr, e_wdata, rdata, obs;
    logic          e_wen;
    logic [MW-1:0] e_wmask;
    cnt = 0;
    for (int n = 0; n < 80; n++) begin
      lv = 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 5) == 0);
      if (!lv && !iv) iv = 1'b1;
      if_req_valid  = iv;
      if_flush      = fl;
      if_req_addr   = 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
      lsu_req_valid = lv;
      lsu_req_addr  = 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
      lsu_req_wen   = 1'($urandom_range(0, 1));
      lsu_req_wdata = {$urandom, $urandom};
      lsu_req_wmask = 8'($urandom_range(0, 255));
      if (!(iv && !fl)) begin
        cnt = 0;
        w   = lv ? 1 : 2;
      end else if (STARVE_EN && cnt == LIMIT) begin
        w   = 0;
        cnt = 0;
      end else if (lv) begin
        w = 1;
        if (cnt < LIMIT) cnt++;
      end else begin
        w   = 0;
        cnt = 0;
      end
      #1;
      checks++; if ({if_req_ready, lsu_req_ready} !== {w == 0, w == 1}) begin errors++; $display("FAIL rnd%0d_grant got=%b exp=%b", n, {if_req_ready, lsu_req_ready}, {w == 0, w == 1}); end
      if (w == 2) begin
        tick();
        continue;
      end
      if (w == 1) begin
        e_addr = lsu_req_addr; e_wen = lsu_req_wen; e_wdata = lsu_req_wdata; e_wmask = lsu_req_wmask;
      end else begin
        e_addr = if_req_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
      end
      dropped = 1'b0;
      tick();
      if_req_valid  = 1'b0;
      lsu_req_valid = 1'b0;
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        f = ($urandom_range(0, 3) == 0); if_flush = f; if (w == 0 && f) dropped = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_req_hold got=%b exp=1", n, mem_req_valid); end
        tick();
      end
      f = ($urandom_range(0, 3) == 0); if_flush = f; if (w == 0 && f) dropped = 1'b1;
      mem_req_ready = 1'b1;
      #1;
      checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, e_addr, e_wen, e_wdata, e_wmask})
        begin errors++; $display("FAIL rnd%0d_payload got=%b/%h/%b/%h/%h exp=1/%h/%b/%h/%h", n, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, e_addr, e_wen, e_wdata, e_wmask); end
      if (e_wen) begin
        mem_write(e_addr, e_wdata, e_wmask);
        rdata = {$urandom, $urandom};
      end else begin
        rdata = mem_read(e_addr);
      end
      tick();
      mem_req_ready = 1'b0;
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        f = ($urandom_range(0, 3) == 0); if_flush = f; if (w == 0 && f) dropped = 1'b1;
        #1;
        checks++; if ({if_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL rnd%0d_early_resp got=%b exp=00", n, {if_resp_valid, lsu_resp_valid}); end
        tick();
      end
      f = ($urandom_range(0, 3) == 0); if_flush = f; if (w == 0 && f) dropped = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      if (w == 1 || !dropped) exp_q.push_back(rdata);
      #1;
      checks++; if ({if_resp_valid, lsu_resp_valid} !== {w == 0 && !dropped, w == 1}) begin errors++; $display("FAIL rnd%0d_resp got=%b exp=%b", n, {if_resp_valid, lsu_resp_valid}, {w == 0 && !dropped, w == 1}); end
      if (if_resp_valid || lsu_resp_valid) begin
        obs = if_resp_valid ? if_resp_rdata : lsu_resp_rdata;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd%0d_unexpected got=%h exp=none", n, obs); end
        else if (obs !== exp_q[0]) begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, obs, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
      tick();
      mem_resp_valid = 1'b0;
      if_flush       = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
    clear_inputs();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_stall();
    test_flush();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF, read-only) and load/store (LSU, read/write).
- Sits between the Ifetch/Exec stages and the memory model/bus.
- LSU has fixed priority; an optional anti-starvation counter guarantees IF progress.
- Drops in-flight IF responses that a taken branch/jump has made stale.

Parameters:
- WIDTH, 64, address and data width.
- MASK_W, 8, write byte-mask width (WIDTH/8).
- STARVE_LIMIT, 4, consecutive lost arbitrations before IF is forced to win (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_addr  in  WIDTH  IF read address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_resp_valid  out  1  IF read data valid.
- if_resp_rdata  out  WIDTH  IF read data.
- if_flush  in  1  branch/jump taken; the outstanding IF access is stale.
- lsu_req_valid  in  1  LSU request.
- lsu_req_addr  in  WIDTH  LSU address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  WIDTH  store data.
- lsu_req_wmask  in  MASK_W  store byte enables.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_resp_valid  out  1  LSU response valid (load data or store acknowledge).
- lsu_resp_rdata  out  WIDTH  LSU load data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  WIDTH  latched address.
- mem_req_wen  out  1  latched write enable.
- mem_req_wdata  out  WIDTH  latched write data.
- mem_req_wmask  out  MASK_W  latched write mask.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  WIDTH  memory read data.
- busy  out  1  state is not IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE -> REQ on a grant.
  - REQ -> RESP on mem_req_valid && mem_req_ready.
  - RESP -> IDLE on mem_resp_valid.
- Exactly one transaction is outstanding at a time; there is no back-to-back grant from RESP.
- Arbitration happens only in IDLE:
  - If lsu_req_valid, LSU wins; otherwise IF wins if if_req_valid && !if_flush.
  - The winner's req_ready is asserted combinationally in that cycle; the loser's req_ready is 0.
  - req_ready is 0 in REQ and RESP.
- On grant, the owner register and the payload (addr/wen/wdata/wmask) are latched. For IF, wen=0, wmask=0 and wdata=0.
- In REQ, mem_req_valid=1 with the latched payload, held stable until mem_req_ready.
- In RESP, responses are combinational pass-through:
  - if_resp_valid = RESP && owner==IF && mem_resp_valid && !drop.
  - lsu_resp_valid = RESP && owner==LSU && mem_resp_valid.
  - rdata is mem_resp_rdata on both response outputs.
- Latency: accept at T, earliest mem_req at T+1, earliest response at T+2.
- Flush handling:
  - if_flush while owner==IF in REQ or RESP sets a drop flag. The memory transaction still completes, but its response is swallowed.
  - The drop flag clears on return to IDLE.
  - if_flush in RESP in the same cycle as mem_resp_valid also suppresses that response.
  - if_flush has no effect while owner==LSU.
- Simultaneous if_req_valid and if_flush in IDLE: IF is not granted.
- Reset: state IDLE, owner IF, drop 0, starvation counter 0, latched payload 0, busy 0.
  - All ready/valid outputs are 0 under reset.
  - Reset mid-transaction abandons it; the memory side is reset by the same rst.

Optional Feature:
- Macro: MEM_ARB_ANTI_STARVE_EN.
- With the macro defined:
  - A saturating counter (width $clog2(STARVE_LIMIT+1)) increments in each IDLE cycle where if_req_valid && !if_flush and LSU wins.
  - When the counter equals STARVE_LIMIT, IF wins that arbitration even if lsu_req_valid.
  - The counter clears on an IF grant, or in any IDLE cycle without an IF request.
- Without the macro: strict LSU priority and no counter logic.

Decomposition:
- Shared package/header (alongside the existing INST_TYPE defines):
  - FSM state encoding (IDLE=0, REQ=1, RESP=2).
  - Owner encoding (OWN_IF=0, OWN_LSU=1).
  - The MEM_ARB_ANTI_STARVE_EN macro.
- One natural sub-module, mem_arb_grant: combinational priority plus starvation-counter logic, producing the grant signals.

Test Plan:
- IF only, addr 0x80000000, memory returns 0x00000013 after 1 cycle: if_req_ready at T, mem_req_valid at T+1, if_resp_valid with 0x13 at T+2; busy high T+1..T+2.
- Both requesters valid in IDLE, LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F: LSU granted first, mem_req_wen=1 with that payload; IF granted next IDLE.
- mem_req_ready held low 3 cycles: payload stable and mem_req_valid held; no req_ready to either master until return to IDLE.
- IF access in RESP, if_flush pulsed one cycle before mem_resp_valid: if_resp_valid stays 0; next IF request served normally.
- With MEM_ARB_ANTI_STARVE_EN and STARVE_LIMIT=4, LSU valid continuously and IF valid continuously: IF granted on the 5th arbitration. Without the macro, IF is never granted.
- rst asserted while in REQ: next cycle state IDLE, busy=0, mem_req_valid=0; a fresh IF request completes normally.
